// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch controller.
package fetch_pkg;

  localparam int unsigned WordBytes = 4;

  typedef enum logic [0:0] {
    StRun,
    StFault
  } state_e;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
  } entry_t;

  // A fetch address is usable only if word aligned and the whole word lies inside memory.
  function automatic logic addr_ok(input logic [31:0] addr, input int unsigned mem_bytes);
    return (addr[1:0] == 2'b00) && (addr <= 32'(mem_bytes - WordBytes));
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry instruction buffer between the memory response and decode.
module fetch_buf
  import fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       push,
  input  entry_t     push_entry,
  input  logic       pop,
  output entry_t     head,
  output logic       full,
  output logic       empty,
  output logic [1:0] count
);

  entry_t     mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;
  logic       do_push;
  logic       do_pop;

  assign empty   = (count_q == 2'd0);
  assign full    = (count_q == 2'd2);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_entry;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues sequential fetches, buffers responses, handles
// redirects and address faults.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int unsigned IMEM_BYTES = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        fault
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        inflight_valid_q, inflight_valid_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;

  logic        pc_ok;
  logic        issue;
  logic        pop;
  logic        push;
  logic [2:0]  pending;
  entry_t      head;
  entry_t      push_entry;
  logic        buf_full;
  logic        buf_empty;
  logic [1:0]  buf_count;

  assign imem_addr  = pc_q;
  assign pc_ok      = addr_ok(pc_q, IMEM_BYTES);
  assign inst_valid = !buf_empty;
  assign inst_data  = buf_empty ? 32'h0 : head.data;
  assign inst_pc    = buf_empty ? 32'h0 : head.pc;
  assign fault      = (state_q == StFault);
  assign pop        = inst_valid && inst_ready;
  assign push       = inflight_valid_q && (!buf_full || pop);
  assign push_entry = '{data: imem_data, pc: inflight_pc_q};

  // Occupancy counts the entry leaving this cycle, so a ready decode sees one word per cycle.
  assign pending = {1'b0, buf_count} + {2'b00, inflight_valid_q} - {2'b00, pop};

  assign issue = (state_q == StRun) && !halt && !redirect_valid && pc_ok && (pending < 3'd2);

  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    inflight_valid_d = inflight_valid_q;
    inflight_pc_d    = inflight_pc_q;
    if (redirect_valid) begin
      pc_d             = redirect_pc;
      inflight_valid_d = 1'b0;
      state_d          = addr_ok(redirect_pc, IMEM_BYTES) ? StRun : StFault;
    end else begin
      inflight_valid_d = issue;
      if (issue) begin
        inflight_pc_d = pc_q;
        pc_d          = pc_q + 32'(WordBytes);
      end
      if ((state_q == StRun) && !pc_ok) begin
        state_d = StFault;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= StRun;
      pc_q             <= RESET_PC;
      inflight_valid_q <= 1'b0;
      inflight_pc_q    <= 32'h0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      inflight_valid_q <= inflight_valid_d;
      inflight_pc_q    <= inflight_pc_d;
    end
  end

  fetch_buf u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect_valid),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .full       (buf_full),
    .empty      (buf_empty),
    .count      (buf_count)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a one-cycle-latency instruction memory model.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        fault;

  logic [31:0] mem [32];
  int          total = 0;
  int          bad   = 0;

  fetch_ctrl #(
    .RESET_PC   (32'h0),
    .IMEM_BYTES (128)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .fault          (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) imem_data <= mem[imem_addr[6:2]];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] exp_pc [4];
    logic [31:0] exp_dt [4];

    mem[0] = 32'h0000_0000;
    mem[1] = 32'h3402_0026;
    mem[2] = 32'h3403_0034;
    mem[3] = 32'h0062_8020;
    mem[4] = 32'hae02_0001;
    for (int i = 5; i < 32; i++) mem[i] = 32'h1000_0000 + 32'(i);
    imem_data      = 32'h0;
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    halt           = 1'b0;
    inst_ready     = 1'b1;
    tick();
    tick();

    // Reset values
    chk("rst_addr",  imem_addr,          32'h0);
    chk("rst_valid", {31'h0, inst_valid}, 32'h0);
    chk("rst_data",  inst_data,          32'h0);
    chk("rst_pc",    inst_pc,            32'h0);
    chk("rst_fault", {31'h0, fault},     32'h0);

    // Back-to-back stream after reset release
    rst_n = 1'b1;
    tick();
    chk("s1_novalid", {31'h0, inst_valid}, 32'h0);
    chk("s1_addr",    imem_addr,           32'h4);
    exp_pc = '{32'h0, 32'h4, 32'h8, 32'hc};
    exp_dt = '{32'h0000_0000, 32'h3402_0026, 32'h3403_0034, 32'h0062_8020};
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("s1_valid", {31'h0, inst_valid}, 32'h1);
      chk("s1_pc",    inst_pc,             exp_pc[i]);
      chk("s1_data",  inst_data,           exp_dt[i]);
    end

    // Backpressure: decode stalls 5 cycles after first valid
    do_reset();
    tick();
    tick();
    chk("bp_first", inst_pc, 32'h0);
    inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", {31'h0, inst_valid}, 32'h1);
      chk("bp_pc",    inst_pc,             32'h0);
      chk("bp_addr",  imem_addr,           32'h8);
    end
    inst_ready = 1'b1;
    exp_pc = '{32'h4, 32'h8, 32'hc, 32'h10};
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_drain", inst_pc, exp_pc[i]);
    end

    // Redirect to 0x10 with pc 8 in flight
    do_reset();
    tick();
    tick();
    tick();
    chk("rd_pre", inst_pc, 32'h4);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h10;
    tick();
    redirect_valid = 1'b0;
    chk("rd_flush", {31'h0, inst_valid}, 32'h0);
    chk("rd_addr",  imem_addr,           32'h10);
    tick();
    chk("rd_gap", {31'h0, inst_valid}, 32'h0);
    tick();
    chk("rd_valid", {31'h0, inst_valid}, 32'h1);
    chk("rd_pc",    inst_pc,             32'h10);
    chk("rd_data",  inst_data,           32'hae02_0001);

    // Run to the top of memory and fault
    rst_n          = 1'b0;
    tick();
    rst_n          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h70;
    tick();
    redirect_valid = 1'b0;
    tick();
    exp_pc = '{32'h70, 32'h74, 32'h78, 32'h7c};
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("end_pc", inst_pc, exp_pc[i]);
      if (i < 3) chk("end_nofault", {31'h0, fault}, 32'h0);
    end
    chk("end_data",  inst_data,       32'h1000_001f);
    chk("end_fault", {31'h0, fault},  32'h1);
    chk("end_addr",  imem_addr,       32'h80);
    tick();
    chk("end_empty", {31'h0, inst_valid}, 32'h0);
    chk("end_hold",  imem_addr,           32'h80);
    chk("end_stick", {31'h0, fault},      32'h1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    tick();
    redirect_valid = 1'b0;
    chk("rec_fault", {31'h0, fault}, 32'h0);
    tick();
    tick();
    chk("rec_valid", {31'h0, inst_valid}, 32'h1);
    chk("rec_pc",    inst_pc,             32'h0);

    // Misaligned redirect faults, reset restarts fetch
    redirect_valid = 1'b1;
    redirect_pc    = 32'h6;
    tick();
    redirect_valid = 1'b0;
    chk("mis_fault", {31'h0, fault},      32'h1);
    chk("mis_valid", {31'h0, inst_valid}, 32'h0);
    tick();
    chk("mis_hold",  imem_addr,           32'h6);
    chk("mis_empty", {31'h0, inst_valid}, 32'h0);
    rst_n = 1'b0;
    tick();
    chk("r2_addr",  imem_addr,           32'h0);
    chk("r2_valid", {31'h0, inst_valid}, 32'h0);
    chk("r2_data",  inst_data,           32'h0);
    chk("r2_pc",    inst_pc,             32'h0);
    chk("r2_fault", {31'h0, fault},      32'h0);
    rst_n = 1'b1;
    tick();
    chk("r2_issue", imem_addr, 32'h4);
    tick();
    chk("r2_first", {31'h0, inst_valid}, 32'h1);
    chk("r2_pc0",   inst_pc,             32'h0);

    // Halt lets the in-flight word land and the buffer drain
    halt = 1'b1;
    tick();
    chk("halt_pc",   inst_pc,   32'h4);
    chk("halt_addr", imem_addr, 32'h8);
    tick();
    chk("halt_drain", {31'h0, inst_valid}, 32'h0);
    chk("halt_stay",  imem_addr,           32'h8);
    halt = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0, the first fetch address after reset.
REQ-002 SHALL have parameter IMEM_BYTES, default 128, the instruction memory size in bytes.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on posedge clk.
REQ-004 SHALL have port rst_n, input, 1, reset: synchronous, active-low.
REQ-005 SHALL have port imem_addr, output, 32, byte address to the instruction memory; memory samples it at posedge and returns the word in the following cycle.
REQ-006 SHALL have port imem_data, input, 32, little-endian word for the address sampled at the previous posedge.
REQ-007 SHALL have port redirect_valid, input, 1, branch/jump redirect request.
REQ-008 SHALL have port redirect_pc, input, 32, redirect target.
REQ-009 SHALL have port halt, input, 1, suppresses new fetch issue while high.
REQ-010 SHALL have port inst_valid, output, 1, an instruction is offered to decode.
REQ-011 SHALL have port inst_ready, input, 1, decode accepts; transfer when inst_valid && inst_ready.
REQ-012 SHALL have port inst_data, output, 32, the offered instruction word.
REQ-013 SHALL have port inst_pc, output, 32, the byte address of inst_data.
REQ-014 SHALL have port fault, output, 1, sticky fetch-address fault.

Function
REQ-015 SHALL hold pc_q; imem_addr SHALL equal pc_q combinationally.
REQ-016 SHALL issue a fetch in a cycle iff state is RUN, halt=0, redirect_valid=0, and buffer occupancy + in-flight count < 2.
REQ-017 On issue, SHALL set inflight_valid=1 and inflight_pc=pc_q, then pc_q <= pc_q+4; without issue, pc_q SHALL hold.
REQ-018 When inflight_valid=1, SHALL write {imem_data, inflight_pc} into a 2-entry FIFO in the next cycle; fetch-to-inst_valid latency is 1 cycle from issue posedge.
REQ-019 inst_valid/inst_data/inst_pc SHALL reflect the FIFO head; pop on inst_valid && inst_ready; push and pop in the same cycle SHALL be allowed.
REQ-020 inst_data/inst_pc SHALL stay stable while inst_valid && !inst_ready.
REQ-021 With decode always ready and no halt, SHALL sustain one instruction per cycle.
REQ-022 redirect_valid=1 SHALL flush the FIFO, clear inflight_valid (response dropped), suppress issue that cycle, and set pc_q <= redirect_pc; inst_valid SHALL be 0 next cycle.
REQ-023 Redirect SHALL take priority over push, pop and issue in the same cycle.
REQ-024 FSM states: RUN, FAULT. RUN->FAULT when the address to be issued is misaligned (bits[1:0]!=0) or > IMEM_BYTES-4; no issue occurs for that address.
REQ-025 No wrap-around: sequential pc reaching IMEM_BYTES SHALL enter FAULT, not roll to 0.
REQ-026 In FAULT, fault=1, no issue; FIFO entries and in-flight response already pending SHALL still drain to decode.
REQ-027 FAULT->RUN only on redirect_valid with an aligned, in-range redirect_pc; fault SHALL clear the next cycle.
REQ-028 halt=1 SHALL not cancel an in-flight fetch nor block draining.

Reset
REQ-029 When rst_n=0 at posedge: pc_q<=RESET_PC, FIFO empty, inflight_valid<=0, state<=RUN.
REQ-030 Output reset values: imem_addr=RESET_PC, inst_valid=0, inst_data=0, inst_pc=0, fault=0.
REQ-031 Reset mid-operation SHALL discard buffered and in-flight instructions; first issue SHALL occur in the first cycle with rst_n=1.

Structure
REQ-032 Shared package fetch_pkg SHALL hold the state enum (RUN, FAULT), word size 4, and the {data,pc} entry typedef.
REQ-033 The 2-entry FIFO SHALL be sub-module fetch_buf (push, pop, flush, full, empty, count).

Verification
REQ-034 Memory preloaded 0x00000000, 0x34020026, 0x34030034, 0x00628020; reset release, inst_ready=1 -> inst_pc 0,4,8,12 on consecutive cycles, with data in order.
REQ-035 inst_ready=0 for 5 cycles after first valid -> inst_valid held, no more than 2 entries + 0 in flight, no loss/duplication after release.
REQ-036 Redirect to 0x10 while pc 8 in flight -> word at 8 never offered; next offered inst_pc=0x10, data 0xae020001.
REQ-037 Run to pc 124 -> inst_pc 124 delivered, then fault=1 and no further issue; redirect_pc=0 -> fault clears, inst_pc 0 follows.
REQ-038 redirect_pc=0x6 -> fault=1 next cycle, inst_valid=0; rst_n=0 one cycle -> all outputs at reset values, fetch restarts at RESET_PC.
